// File: rtl/flux_seq_pkg.sv
// Shared types and defaults for the spectral flux frame sequencer.
//   seq_state_t : sequencer FSM states
//   bin_idx_t   : bin index at the default frame size
//   DEF_*       : default values for the top-level parameters
package flux_seq_pkg;

    localparam int DEF_BIN_LENGTH     = 10;
    localparam int DEF_DRAIN_CYCLES   = 3;
    localparam int DEF_RESULT_TIMEOUT = 15;

    typedef logic [DEF_BIN_LENGTH:0] bin_idx_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STREAM   = 3'd1,
        S_RESYNC   = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4,
        S_WAIT_RES = 3'd5
    } seq_state_t;

endpackage

// File: rtl/flux_frame_sequencer_beat_gate.sv
// Refractory gate on the flux beat decision.
//   clk, reset_n  : clock, asynchronous active-low reset
//   result_stb    : a flux result is consumed this cycle
//   timeout_stb   : the flux result for this frame never arrived
//   beat_valid    : raw beat decision, meaningful with result_stb
//   beat_out      : 1-cycle pulse for an accepted beat
//   beat_interval : frames since the previous accepted beat, held
module flux_frame_sequencer_beat_gate #(
    parameter int MIN_BEAT_GAP = 8,
    parameter int IW           = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          result_stb,
    input  logic          timeout_stb,
    input  logic          beat_valid,
    output logic          beat_out,
    output logic [IW-1:0] beat_interval
);

    logic [IW-1:0] frames_since_beat;

    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The count includes the frame carrying the beat, so the accepted
    // beat's frame restarts the count at 1, not 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_since_beat <= '0;
            beat_out          <= 1'b0;
            beat_interval     <= '0;
        end else begin
            beat_out <= 1'b0;
            if (result_stb) begin
                if (beat_valid && (frames_since_beat >= IW'(MIN_BEAT_GAP))) begin
                    beat_out          <= 1'b1;
                    beat_interval     <= frames_since_beat;
                    frames_since_beat <= IW'(1);
                end else begin
                    frames_since_beat <= sat_inc(frames_since_beat);
                end
            end else if (timeout_stb) begin
                frames_since_beat <= sat_inc(frames_since_beat);
            end
        end
    end

endmodule

// File: rtl/flux_frame_sequencer.sv
// Frame sequencer between the FFT magnitude stream and spectral_flux.
// Forwards one frame of N mag_sq bins with a bin index, drains the flux
// pipeline, pulses frame_done, waits for the flux result and gates beats.
//   clk, reset_n                     : clock, asynchronous active-low reset
//   enable                           : run/stop, sampled at frame boundaries
//   in_valid/in_ready/in_mag/in_last : upstream bin stream
//   mag_valid/mag_sq/bin_index       : registered bin stream to flux
//   frame_done                       : 1-cycle end-of-frame pulse to flux
//   flux_valid/beat_valid            : flux result
//   beat_out/beat_interval           : gated beat and its interval in frames
//   frame_count                      : completed frames (wraps)
//   busy                             : sequencer not idle
//   err_short/err_long/err_timeout   : sticky framing/result errors
module flux_frame_sequencer
    import flux_seq_pkg::*;
#(
    parameter int N              = 1024,
    parameter int W              = 32,
    parameter int BIN_LENGTH     = DEF_BIN_LENGTH,
    parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int RESULT_TIMEOUT = DEF_RESULT_TIMEOUT,
    parameter int MIN_BEAT_GAP   = 8,
    parameter int IW             = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_mag,
    input  logic                in_last,
    output logic                mag_valid,
    output logic [W-1:0]        mag_sq,
    output logic [BIN_LENGTH:0] bin_index,
    output logic                frame_done,
    input  logic                flux_valid,
    input  logic                beat_valid,
    output logic                beat_out,
    output logic [IW-1:0]       beat_interval,
    output logic [IW-1:0]       frame_count,
    output logic                busy,
    output logic                err_short,
    output logic                err_long,
    output logic                err_timeout
);

    localparam int BW = BIN_LENGTH + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int TW = $clog2(RESULT_TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BIN   = BW'(N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RESULT_TIMEOUT - 1);

    seq_state_t    state;
    logic [BW-1:0] bin_cnt;
    logic [DW-1:0] drain_cnt;
    logic [TW-1:0] timer;
    logic          xfer;
    logic          result_stb;
    logic          timeout_stb;

    // in_ready is registered and high exactly in STREAM/RESYNC.
    assign xfer        = in_valid & in_ready;
    assign result_stb  = (state == S_WAIT_RES) && flux_valid;
    assign timeout_stb = (state == S_WAIT_RES) && !flux_valid && (timer == TIMER_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            mag_valid   <= 1'b0;
            mag_sq      <= '0;
            bin_index   <= '0;
            bin_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_timeout <= 1'b0;
            drain_cnt   <= '0;
            timer       <= '0;
        end else begin
            mag_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state    <= S_STREAM;
                        bin_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        mag_valid <= 1'b1;
                        mag_sq    <= in_mag;
                        bin_index <= bin_cnt;
                        bin_cnt   <= bin_cnt + 1'b1;
                        if (in_last) begin
                            // bin_cnt never exceeds LAST_BIN in STREAM
                            if (bin_cnt != LAST_BIN) begin
                                err_short <= 1'b1;
                            end
                            state     <= S_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end else if (bin_cnt == LAST_BIN) begin
                            err_long <= 1'b1;
                            state    <= S_RESYNC;
                        end
                    end
                end
                S_RESYNC: begin
                    // Overlong frame: swallow bins until the upstream marks the end.
                    if (xfer && in_last) begin
                        state     <= S_DRAIN;
                        in_ready  <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    state      <= S_WAIT_RES;
                    timer      <= '0;
                end
                S_WAIT_RES: begin
                    if (flux_valid || (timer == TIMER_LAST)) begin
                        if (flux_valid) begin
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            err_timeout <= 1'b1;
                        end
                        if (enable) begin
                            state    <= S_STREAM;
                            bin_cnt  <= '0;
                            in_ready <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    flux_frame_sequencer_beat_gate #(
        .MIN_BEAT_GAP (MIN_BEAT_GAP),
        .IW           (IW)
    ) u_beat_gate (
        .clk           (clk),
        .reset_n       (reset_n),
        .result_stb    (result_stb),
        .timeout_stb   (timeout_stb),
        .beat_valid    (beat_valid),
        .beat_out      (beat_out),
        .beat_interval (beat_interval)
    );

endmodule

// File: tb/tb_flux_frame_sequencer.sv
// Bench for flux_frame_sequencer with N=8, DRAIN_CYCLES=3, MIN_BEAT_GAP=2,
// RESULT_TIMEOUT=15: directed and randomized frames against a frame-level model.
module tb_flux_frame_sequencer;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int BL    = 10;
    localparam int DRAIN = 3;
    localparam int TMO   = 15;
    localparam int GAP   = 2;
    localparam int IW    = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_mag;
    logic          in_last;
    logic          mag_valid;
    logic [W-1:0]  mag_sq;
    logic [BL:0]   bin_index;
    logic          frame_done;
    logic          flux_valid;
    logic          beat_valid;
    logic          beat_out;
    logic [IW-1:0] beat_interval;
    logic [IW-1:0] frame_count;
    logic          busy;
    logic          err_short;
    logic          err_long;
    logic          err_timeout;

    always #5 clk = ~clk;

    flux_frame_sequencer #(
        .N(N), .W(W), .BIN_LENGTH(BL), .DRAIN_CYCLES(DRAIN),
        .RESULT_TIMEOUT(TMO), .MIN_BEAT_GAP(GAP), .IW(IW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_last(in_last),
        .mag_valid(mag_valid), .mag_sq(mag_sq), .bin_index(bin_index),
        .frame_done(frame_done), .flux_valid(flux_valid), .beat_valid(beat_valid),
        .beat_out(beat_out), .beat_interval(beat_interval), .frame_count(frame_count),
        .busy(busy), .err_short(err_short), .err_long(err_long), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // frame-level reference model
    logic [63:0] exp_q[$];
    int          m_fc, m_fsb, m_int, m_beats, beat_seen;
    bit          m_err_short, m_err_long, m_err_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fc = 0; m_fsb = 0; m_int = 0;
        m_err_short = 0; m_err_long = 0; m_err_to = 0;
    endtask

    task automatic model_result(input bit got_flux, input bit beat, output bit exp_beat);
        exp_beat = 1'b0;
        if (got_flux) begin
            m_fc = (m_fc + 1) % 256;
            if (beat && m_fsb >= GAP) begin
                exp_beat = 1'b1;
                m_int    = m_fsb;
                m_fsb    = 1;
                m_beats++;
            end else if (m_fsb < 255) begin
                m_fsb++;
            end
        end else begin
            m_err_to = 1'b1;
            if (m_fsb < 255) m_fsb++;
        end
    endtask

    // Every forwarded bin must match the next bin the model expects.
    always @(negedge clk) begin
        if (reset_n && mag_valid) begin
            if (exp_q.size() == 0) begin
                check("mag_valid_spurious", 64'(mag_valid), 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("bin_index", 64'(bin_index), {32'd0, e[63:32]});
                check("mag_sq", 64'(mag_sq), {32'd0, e[31:0]});
            end
        end
        if (reset_n && beat_out) beat_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // last_pos: 1-based bin carrying in_last; fdelay < 0 withholds flux_valid
    task automatic do_frame(input int last_pos, input int gap_pct, input bit ramp,
                            input int fdelay, input bit beat, input bit en_after,
                            input bit stray);
        int sent = 0;
        int w;
        bit eb;
        enable = 1'b1;
        while (sent < last_pos) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                continue;
            end
            in_valid   = 1'b1;
            in_mag     = ramp ? W'(sent + 1) : $urandom;
            in_last    = (sent + 1 == last_pos);
            flux_valid = stray && (sent < 2);
            beat_valid = stray && (sent < 2);
            if (sent == 2 && !en_after) enable = 1'b0;
            w = 0;
            while (!in_ready && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
            if (sent < N) exp_q.push_back({32'(sent), in_mag});
            sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; flux_valid = 1'b0; beat_valid = 1'b0;
        if (last_pos < N) m_err_short = 1'b1;
        if (last_pos > N) m_err_long = 1'b1;
        check("busy_drain", 64'(busy), 64'd1);
        for (int k = 0; k <= DRAIN + 1; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check("frame_done", 64'(frame_done), 64'(k == DRAIN + 1));
        end
        enable = en_after;
        if (fdelay >= 0) begin
            for (int k = 0; k < fdelay; k++) begin
                @(posedge clk); #1;
            end
            flux_valid = 1'b1; beat_valid = beat;
            @(posedge clk); #1;
            flux_valid = 1'b0; beat_valid = 1'b0;
            model_result(1'b1, beat, eb);
        end else begin
            beat_valid = beat;
            for (int k = 1; k < TMO; k++) begin
                @(posedge clk); #1;
            end
            check("err_timeout_early", 64'(err_timeout), 64'(m_err_to));
            @(posedge clk); #1;
            beat_valid = 1'b0;
            model_result(1'b0, beat, eb);
        end
        check("frame_done_fall", 64'(frame_done), 64'd0);
        check("frame_count", 64'(frame_count), 64'(m_fc));
        check("err_timeout", 64'(err_timeout), 64'(m_err_to));
        check("err_short", 64'(err_short), 64'(m_err_short));
        check("err_long", 64'(err_long), 64'(m_err_long));
        check("beat_out", 64'(beat_out), 64'(eb));
        check("beat_interval", 64'(beat_interval), 64'(m_int));
        check("busy_after", 64'(busy), 64'(en_after));
        check("in_ready_after", 64'(in_ready), 64'(en_after));
        @(posedge clk); #1;
        check("beat_out_pulse", 64'(beat_out), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_mag_valid"}, 64'(mag_valid), 64'd0);
        check({tag, "_mag_sq"}, 64'(mag_sq), 64'd0);
        check({tag, "_bin_index"}, 64'(bin_index), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_beat_out"}, 64'(beat_out), 64'd0);
        check({tag, "_beat_interval"}, 64'(beat_interval), 64'd0);
        check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err_short"}, 64'(err_short), 64'd0);
        check({tag, "_err_long"}, 64'(err_long), 64'd0);
        check({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    endtask

    initial begin
        int lp, fd, w;
        reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_mag = '0; in_last = 1'b0;
        flux_valid = 1'b0; beat_valid = 1'b0;
        m_beats = 0; beat_seen = 0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // frames 0..5 from reset: beats requested on frames 2, 3 and 5
        do_frame(N, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        do_frame(N, 50, 1'b0, 4, 1'b0, 1'b1, 1'b0);
        do_frame(N, 0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
        do_frame(N, 20, 1'b0, 5, 1'b1, 1'b1, 1'b0);
        do_frame(N, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0);
        do_frame(N, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        check("beat_interval_f5", 64'(beat_interval), 64'd3);

        // short, normal restart, long, timeout, enable dropped mid-frame
        do_frame(5, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        do_frame(N, 0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        do_frame(N + 3, 0, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        do_frame(N, 0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
        do_frame(N, 30, 1'b0, 6, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in_mag = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("idle_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;

        for (int f = 0; f < 20; f++) begin
            w = $urandom_range(9);
            if (w < 6) lp = N;
            else if (w < 8) lp = $urandom_range(N - 1, 1);
            else lp = $urandom_range(N + 4, N + 1);
            fd = ($urandom_range(7) == 0) ? -1 : $urandom_range(12);
            do_frame(lp, $urandom_range(60), 1'b0, fd, 1'($urandom_range(1)),
                     1'($urandom_range(3) != 0), 1'($urandom_range(1)));
        end

        // reset in the middle of a frame
        enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_mag = $urandom; in_last = 1'b0;
            w = 0;
            while (!in_ready && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) check("in_ready_wait_rst", 64'(in_ready), 64'd1);
            exp_q.push_back({32'(b), in_mag});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        reset_n = 1'b1;
        do_frame(N, 10, 1'b1, 3, 1'b1, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("beat_count", 64'(beat_seen), 64'(m_beats));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
